// File: rtl/mult_pkg.sv
// Shared constants and FSM state encodings for the iterative signed multiplier.
package mult_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_COUNT_W = $clog2(DEF_WIDTH) + 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/multiply.sv
// Iterative WIDTHxWIDTH signed multiplier: shift-and-add on operand magnitudes,
// one multiplier bit per clock, sign applied when the result is written.
module multiply
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mult_begin,
    input  logic [WIDTH-1:0]     mult_op1,
    input  logic [WIDTH-1:0]     mult_op2,
    output logic [2*WIDTH-1:0]   product,
    output logic                 mult_end
);

    localparam int unsigned COUNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PROD_W  = 2 * WIDTH;

    state_t              state;
    state_t              state_nxt;
    logic [PROD_W-1:0]   mcand;
    logic [PROD_W-1:0]   mcand_nxt;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   acc_nxt;
    logic [PROD_W-1:0]   acc_sum;
    logic [PROD_W-1:0]   product_nxt;
    logic [WIDTH-1:0]    mplier;
    logic [WIDTH-1:0]    mplier_nxt;
    logic                sign;
    logic                sign_nxt;
    logic                mult_end_nxt;
    logic [COUNT_W-1:0]  cnt;
    logic [COUNT_W-1:0]  cnt_nxt;

    // Magnitude as an unsigned value; the most negative input maps exactly.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            sign     <= 1'b0;
            cnt      <= '0;
            product  <= '0;
            mult_end <= 1'b0;
        end else begin
            state    <= state_nxt;
            mcand    <= mcand_nxt;
            mplier   <= mplier_nxt;
            acc      <= acc_nxt;
            sign     <= sign_nxt;
            cnt      <= cnt_nxt;
            product  <= product_nxt;
            mult_end <= mult_end_nxt;
        end
    end

    // Next-state and datapath update; the final add is folded into the DONE write.
    always_comb begin
        state_nxt    = state;
        mcand_nxt    = mcand;
        mplier_nxt   = mplier;
        acc_nxt      = acc;
        sign_nxt     = sign;
        cnt_nxt      = cnt;
        product_nxt  = product;
        mult_end_nxt = mult_end;
        acc_sum      = acc + (mplier[0] ? mcand : '0);

        case (state)
            ST_IDLE: begin
                mult_end_nxt = 1'b0;
                if (mult_begin) begin
                    state_nxt  = ST_BUSY;
                    mcand_nxt  = {{WIDTH{1'b0}}, abs_val(mult_op1)};
                    mplier_nxt = abs_val(mult_op2);
                    sign_nxt   = mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1];
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                end
            end
            ST_BUSY: begin
                if (!mult_begin) begin
                    state_nxt = ST_IDLE;
                end else begin
                    acc_nxt    = acc_sum;
                    mcand_nxt  = mcand << 1;
                    mplier_nxt = mplier >> 1;
                    cnt_nxt    = cnt + COUNT_W'(1);
                    if (cnt == COUNT_W'(WIDTH - 1)) begin
                        state_nxt    = ST_DONE;
                        product_nxt  = sign ? -acc_sum : acc_sum;
                        mult_end_nxt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!mult_begin) begin
                    state_nxt    = ST_IDLE;
                    mult_end_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                mult_end_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multiply.sv
// Scoreboarded bench for the iterative signed multiplier.
module tb_multiply;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mult_begin = 1'b0;
    logic [31:0] mult_op1 = '0;
    logic [31:0] mult_op2 = '0;
    logic [63:0] product;
    logic        mult_end;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb[$];
    logic [63:0] last_result = '0;

    multiply dut (
        .clk        (clk),
        .rst        (rst),
        .mult_begin (mult_begin),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end)
    );

    always #5 clk = ~clk;

    // Reference product from the simulator's own signed multiply.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb_;
        sa  = $signed({{32{a[31]}}, a});
        sb_ = $signed({{32{b[31]}}, b});
        return 64'(sa * sb_);
    endfunction

    // Raise mult_begin with operands, push the expectation, and count edges to mult_end.
    // Operands are scrambled after change_at edges (0 = never). edges = -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int change_at, output int edges);
        @(negedge clk);
        mult_op1   = a;
        mult_op2   = b;
        mult_begin = 1'b1;
        sb.push_back(model(a, b));
        edges = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == change_at) begin
                mult_op1 = $urandom;
                mult_op2 = $urandom;
            end
            if (mult_end) begin
                edges = i;
                break;
            end
        end
    endtask

    // Pop the scoreboard and check latency and product of the finished operation.
    task automatic check_done(input string name, input int edges);
        logic [63:0] exp;
        exp = sb.size() > 0 ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        n_checks++;
        if (edges !== 33) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, expected 33", name, edges);
        end
        n_checks++;
        if (product !== exp) begin
            n_fail++;
            $display("FAIL %s product: got %h, expected %h", name, product, exp);
        end
        last_result = exp;
    endtask

    task automatic drop_begin(input string name);
        @(negedge clk);
        mult_begin = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (mult_end !== 1'b0 || product !== last_result) begin
            n_fail++;
            $display("FAIL %s release: mult_end=%b product=%h, expected 0 and %h",
                     name, mult_end, product, last_result);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (product !== 64'h0 || mult_end !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: product=%h mult_end=%b, expected 0 and 0", product, mult_end);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int edges;
        int bad;
        run_op(32'h0000_1111, 32'h0000_1111, 0, edges);
        check_done("basic_1111", edges);
        n_checks++;
        if (product !== 64'h0000_0000_0123_4321) begin
            n_fail++;
            $display("FAIL basic_const: got %h, expected 0000000001234321", product);
        end
        // Hold mult_begin to 40 edges total: result must stay put, no restart.
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (mult_end !== 1'b1 || product !== 64'h0000_0000_0123_4321) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL basic_hold: %0d bad cycles (mult_end=%b product=%h), expected 0",
                     bad, mult_end, product);
        end
        drop_begin("basic_1111");

        run_op(32'h0000_1111, 32'h0000_2222, 0, edges);
        check_done("basic_2222", edges);
        n_checks++;
        if (product !== 64'h0000_0000_0246_8642) begin
            n_fail++;
            $display("FAIL basic_2222_const: got %h, expected 0000000002468642", product);
        end
        drop_begin("basic_2222");
    endtask

    task automatic test_signed;
        logic [31:0] a_tab[6]   = '{32'h0000_0002, 32'h0000_0002, 32'h8000_0000,
                                    32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] b_tab[6]   = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                    32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
        logic [63:0] exp_tab[6] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_0000_0000,
                                    64'h4000_0000_0000_0000, 64'h0, 64'h0,
                                    64'hC000_0000_8000_0000};
        int edges;
        for (int i = 0; i < 6; i++) begin
            run_op(a_tab[i], b_tab[i], 0, edges);
            check_done("signed", edges);
            n_checks++;
            if (product !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL signed_const[%0d]: got %h, expected %h", i, product, exp_tab[i]);
            end
            drop_begin("signed");
        end
    endtask

    task automatic test_random;
        int edges;
        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, 0, edges);
            check_done("random", edges);
            drop_begin("random");
        end
    endtask

    task automatic test_operand_change;
        int edges;
        run_op(32'hFFFF_F00D, 32'h0012_3457, 5, edges);
        check_done("operand_change", edges);
        drop_begin("operand_change");
    endtask

    task automatic test_abort;
        int seen_end;
        int bad_prod;
        @(negedge clk);
        mult_op1   = 32'h0000_0003;
        mult_op2   = 32'h0000_0005;
        mult_begin = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        mult_begin = 1'b0;
        seen_end = 0;
        bad_prod = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mult_end !== 1'b0) seen_end++;
            if (product !== last_result) bad_prod++;
        end
        n_checks++;
        if (seen_end != 0) begin
            n_fail++;
            $display("FAIL abort_end: mult_end high on %0d cycles, expected 0", seen_end);
        end
        n_checks++;
        if (bad_prod != 0) begin
            n_fail++;
            $display("FAIL abort_product: got %h, expected %h", product, last_result);
        end
    endtask

    task automatic test_reset_mid;
        int edges;
        @(negedge clk);
        mult_op1   = 32'h1234_5678;
        mult_op2   = 32'h8765_4321;
        mult_begin = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst        = 1'b1;
        mult_begin = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (product !== 64'h0 || mult_end !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: product=%h mult_end=%b, expected 0 and 0", product, mult_end);
        end
        last_result = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h1234_5678, 32'h8765_4321, 0, edges);
        check_done("after_reset", edges);
        drop_begin("after_reset");
    endtask

    task automatic test_back_to_back;
        int edges;
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, edges);
        check_done("b2b_first", edges);
        drop_begin("b2b_first");
        run_op(32'hFFFF_FFFE, 32'h0000_0009, 0, edges);
        check_done("b2b_second", edges);
        drop_begin("b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_random();
        test_operand_change();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiply.md
Name: multiply

Overview:
- Iterative 32x32 signed (two's-complement) multiplier producing a 64-bit product.
- Uses a shift-and-add datapath on operand magnitudes, one multiplier bit per clock, with sign correction at the end.
- Sits beside the ALU in the lab CPU datapath.
- Uses a level-held start request (mult_begin) and a completion flag (mult_end).

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- mult_begin  input  1  start/hold request; must stay high until mult_end is seen.
- mult_op1  input  WIDTH  multiplicand, signed two's complement.
- mult_op2  input  WIDTH  multiplier, signed two's complement.
- product  output  2*WIDTH  signed result, registered.
- mult_end  output  1  high while a finished result is valid and mult_begin is still high.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at an edge): state IDLE, product=0, mult_end=0, counter=0. Reset wins over every other event, including mid-operation.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on the first edge that samples mult_begin=1. At that edge, latch:
  - |mult_op1| into a 2*WIDTH multiplicand register;
  - |mult_op2| into a WIDTH multiplier register;
  - result sign = op1[WIDTH-1] XOR op2[WIDTH-1];
  - clear the accumulator and counter.
- Operands are sampled only at that edge; later changes are ignored.
- BUSY, each edge:
  - if multiplier LSB=1, accumulator += multiplicand;
  - multiplicand <<= 1; multiplier >>= 1; counter++.
  - After WIDTH (32) BUSY edges -> DONE.
- DONE entry edge:
  - product <= sign ? -(final accumulator) : final accumulator;
  - mult_end <= 1.
  - Latency: mult_end and product are valid after exactly 33 rising edges, counted from the first edge that sampled mult_begin=1.
- DONE: product and mult_end hold while mult_begin=1. No restart while mult_begin stays high.
- mult_begin=0 in DONE: next edge -> IDLE, mult_end=0; product retains the last result.
- mult_begin=0 in BUSY: abort; next edge -> IDLE, mult_end stays 0, product unchanged.
- Magnitude arithmetic:
  - Absolute values are WIDTH-bit unsigned, so |-2^31| = 0x80000000 is exact.
  - The accumulator is 2*WIDTH bits and never overflows.
  - Final negation is 2*WIDTH-bit two's complement.
- Zero operands follow the normal 32-cycle path (no early exit) and give product 0 with sign irrelevant; -0 must not appear.
- A new operation requires mult_begin to go low for at least one edge, then high again.

Decomposition:
- Shared package mult_pkg: WIDTH default constant; state enum {IDLE, BUSY, DONE}; COUNT_W = $clog2(WIDTH)+1.
- No sub-module needed. Control FSM and datapath (abs, shift/add, sign fix) live in one module; abs/negate may be local functions.

Test Plan:
- op1=0x00001111, op2=0x00001111, mult_begin high 40 cycles -> mult_end rises on edge 33; product=0x0000000001234321; holds until mult_begin low.
- op1=0x00001111, op2=0x00002222 -> product=0x0000000002468642; mult_end deasserts one edge after mult_begin drops.
- op1=0x00000002, op2=0xFFFFFFFF -> product=0xFFFFFFFFFFFFFFFE (signed, -2).
- op1=0x00000002, op2=0x80000000 -> product=0xFFFFFFFF00000000. Also op1=op2=0x80000000 -> 0x4000000000000000.
- Change operands while BUSY -> result still uses the operands latched at start. Drop mult_begin at cycle 10 -> IDLE, mult_end never asserts, product keeps the previous result.
- rst=1 at cycle 15 of an operation -> next edge: product=0, mult_end=0, IDLE. A fresh mult_begin then completes normally in 33 edges.
